frame_bank_ctrl: RTL

Double-buffer controller between the host-side pixel writer and the LED `driver`. It owns two single-port frame RAM banks of `c_channels` × `c_bps` bits. The driver always reads the front bank, and the host always writes the back bank. On host commit, the banks swap at the driver's next latch request (`o_drq`), so the LEDs never latch a partially written frame.

---
 rtl/frame_bank_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/frame_bank_ctrl.sv
// rtl/frame_bank_ctrl.sv - double-buffered frame RAM bank controller
// Driver reads the front bank, host writes the back bank; banks swap on the first latch after commit.
module frame_bank_ctrl #(
  parameter int c_channels = 960,
  parameter int c_addr_w   = $clog2(c_channels),
  parameter int c_bps      = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [c_addr_w-1:0] i_rd_addr,
  input  logic                i_rd,
  output logic [c_bps-1:0]    o_rd_data,
  input  logic                i_drq,
  input  logic [c_addr_w-1:0] i_wr_addr,
  input  logic [c_bps-1:0]    i_wr_data,
  input  logic                i_wr_valid,
  output logic                o_wr_ready,
  input  logic                i_commit,
  output logic                o_pending,
  output logic                o_swap,
  output logic                o_front,
  output logic [15:0]         o_frames,
  output logic                o_wr_err,
  output logic [c_addr_w-1:0] o_a_addr,
  output logic                o_a_we,
  output logic [c_bps-1:0]    o_a_wdata,
  input  logic [c_bps-1:0]    i_a_rdata,
  output logic [c_addr_w-1:0] o_b_addr,
  output logic                o_b_we,
  output logic [c_bps-1:0]    o_b_wdata,
  input  logic [c_bps-1:0]    i_b_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_SWAP    = 2'd2;

  localparam logic [c_addr_w:0] c_lim = (c_addr_w + 1)'(c_channels);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nx;
  logic        r_front;
  logic        r_front_d;
  logic        r_drq_q;
  logic        r_wr_err;
  logic [15:0] r_frames;

  logic w_idle;
  logic w_drq_rise;
  logic w_accept;
  logic w_in_range;
  logic w_back_we;
  logic w_commit_ok;
  logic w_unused_rd;

  // The RAM reads every cycle, so the driver's read strobe carries no information here.
  assign w_unused_rd = i_rd;

  assign w_idle      = (r_state == S_IDLE);
  assign w_drq_rise  = i_drq & ~r_drq_q;
  assign w_accept    = i_wr_valid & w_idle;
  assign w_in_range  = ({1'b0, i_wr_addr} < c_lim);
  assign w_back_we   = w_accept & w_in_range;
  assign w_commit_ok = w_idle & i_commit;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (i_commit) w_state_nx = S_PENDING;
      S_PENDING: if (w_drq_rise) w_state_nx = S_SWAP;
      S_SWAP:    w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_front   <= 1'b0;
      r_front_d <= 1'b0;
      r_drq_q   <= 1'b0;
      r_wr_err  <= 1'b0;
      r_frames  <= 16'd0;
    end else begin
      r_state   <= w_state_nx;
      r_drq_q   <= i_drq;
      r_front_d <= r_front;
      if (r_state == S_SWAP) begin
        r_front  <= ~r_front;
        r_frames <= r_frames + 16'd1;
      end
      // A bad write in the same cycle as the commit keeps the error visible.
      if (w_accept & ~w_in_range) begin
        r_wr_err <= 1'b1;
      end else if (w_commit_ok) begin
        r_wr_err <= 1'b0;
      end
    end
  end

  assign o_wr_ready = w_idle;
  assign o_pending  = (r_state == S_PENDING);
  assign o_swap     = (r_state == S_SWAP);
  assign o_front    = r_front;
  assign o_frames   = r_frames;
  assign o_wr_err   = r_wr_err;

  assign o_a_addr  = r_front ? i_wr_addr : i_rd_addr;
  assign o_a_we    = r_front & w_back_we;
  assign o_a_wdata = i_wr_data;
  assign o_b_addr  = r_front ? i_rd_addr : i_wr_addr;
  assign o_b_we    = ~r_front & w_back_we;
  assign o_b_wdata = i_wr_data;

  // Select by the front bank of the previous cycle, matching the RAM's read latency.
  assign o_rd_data = r_front_d ? i_b_rdata : i_a_rdata;

endmodule
